// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader: accepts config bytes over valid/ready and serialises them MSB-first onto the PAL CFG/EN pins.
// Ports:
//   CLK, RES         clock (rising edge), asynchronous active-high reset
//   START, ABORT     begin a load (IDLE only) / synchronous abort of a load in progress
//   DATA_IN, VALID   configuration byte and its valid strobe
//   READY            byte accepted this cycle when VALID is also high
//   CFG_EN, CFG_BIT  PAL shift enable and serial data
//   BUSY, DONE, ERR  load in progress, one-cycle completion pulse, checksum mismatch
// Optional feature: define PAL_CFG_CRC_EN to append a CRC-8 (poly 0x07, init 0) byte that is
// checked but not shifted; otherwise ERR is tied low.
module pal_cfg_loader #(
    parameter int SR_LEN = 192,
    parameter int W      = 8
) (
    input  logic         CLK,
    input  logic         RES,
    input  logic         START,
    input  logic         ABORT,
    input  logic [W-1:0] DATA_IN,
    input  logic         VALID,
    output logic         READY,
    output logic         CFG_EN,
    output logic         CFG_BIT,
    output logic         BUSY,
    output logic         DONE,
    output logic         ERR
);
    localparam int NBYTES = (SR_LEN + W - 1) / W;
    localparam int BTW = $clog2(W + 1);
    localparam int BCW = $clog2(NBYTES + 1);
    localparam logic [BTW-1:0] LAST_BIT = BTW'(W - 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

`ifdef PAL_CFG_CRC_EN
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CHECK, FINISH} state_t;
    localparam state_t TAIL = CHECK;
`else
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, FINISH} state_t;
    localparam state_t TAIL = FINISH;
`endif

    state_t state, nxt;
    logic [W-1:0] sr;
    logic [BTW-1:0] bit_cnt;
    logic [BCW-1:0] byte_cnt;
    logic hs;

    assign hs = VALID & READY;
    assign CFG_BIT = sr[W-1];

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) state <= IDLE;
        else     state <= nxt;
    end

    // READY is masked by ABORT so an aborted cycle never consumes a byte
    always_comb begin
        nxt    = state;
        READY  = 1'b0;
        CFG_EN = state == SHIFT;
        BUSY   = state != IDLE;
        DONE   = state == FINISH;
        case (state)
            IDLE:    nxt = START ? LOAD : IDLE;
            LOAD: begin
                READY = !ABORT;
                nxt   = ABORT ? IDLE : VALID ? SHIFT : LOAD;
            end
            SHIFT:   nxt = ABORT ? IDLE : bit_cnt != LAST_BIT ? SHIFT : byte_cnt != LAST_BYTE ? LOAD : TAIL;
`ifdef PAL_CFG_CRC_EN
            CHECK: begin
                READY = !ABORT;
                nxt   = ABORT ? IDLE : VALID ? FINISH : CHECK;
            end
`endif
            FINISH:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Counters clear whenever the FSM heads back to IDLE (finish or abort)
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            sr       <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
        end else if (nxt == IDLE) begin
            sr       <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
        end else if (state == LOAD && hs) begin
            sr <= DATA_IN;
        end else if (CFG_EN) begin
            sr      <= {sr[W-2:0], 1'b0};
            bit_cnt <= bit_cnt == LAST_BIT ? '0 : bit_cnt + BTW'(1);
            if (bit_cnt == LAST_BIT) byte_cnt <= byte_cnt + BCW'(1);
        end
    end

`ifdef PAL_CFG_CRC_EN
    logic [7:0] crc;

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [W-1:0] d);
        logic [7:0] r;
        r = c;
        for (int i = W - 1; i >= 0; i--) r = {r[6:0], 1'b0} ^ ((r[7] ^ d[i]) ? 8'h07 : 8'h00);
        return r;
    endfunction

    // ERR survives FINISH and is cleared only by the next START
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            crc <= '0;
            ERR <= 1'b0;
        end else if (state == IDLE) begin
            crc <= '0;
            if (START) ERR <= 1'b0;
        end else if (state == LOAD && hs) begin
            crc <= crc8(crc, DATA_IN);
        end else if (state == CHECK && hs) begin
            ERR <= DATA_IN != W'(crc);
        end
    end
`else
    assign ERR = 1'b0;
`endif
endmodule

// File: tb/tb_pal_cfg_loader.sv
module tb_pal_cfg_loader;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    bit sel = 1'b0;
    logic [1:0] rdy, en, cb, bsy, dn, er;
    logic ready, cfg_en, cfg_bit, busy, done, err;

    int checks = 0, passes = 0;
    int en_cnt, ready_cnt, done_cnt, bursts, bad_burst, run;
    logic bits[$];
    logic [255:0] chain;
    logic [7:0] stream[$];
`ifdef PAL_CFG_CRC_EN
    localparam int CRC_EXTRA = 1;
    bit bad_crc = 1'b0;
`else
    localparam int CRC_EXTRA = 0;
`endif

    always #5 clk = ~clk;

    pal_cfg_loader #(.SR_LEN(192), .W(8)) d0 (
        .CLK(clk), .RES(rst), .START(start & !sel), .ABORT(abort & !sel), .DATA_IN(data_in),
        .VALID(valid & !sel), .READY(rdy[0]), .CFG_EN(en[0]), .CFG_BIT(cb[0]), .BUSY(bsy[0]),
        .DONE(dn[0]), .ERR(er[0])
    );
    pal_cfg_loader #(.SR_LEN(12), .W(8)) d1 (
        .CLK(clk), .RES(rst), .START(start & sel), .ABORT(abort & sel), .DATA_IN(data_in),
        .VALID(valid & sel), .READY(rdy[1]), .CFG_EN(en[1]), .CFG_BIT(cb[1]), .BUSY(bsy[1]),
        .DONE(dn[1]), .ERR(er[1])
    );

    assign ready = rdy[sel];
    assign cfg_en = en[sel];
    assign cfg_bit = cb[sel];
    assign busy = bsy[sel];
    assign done = dn[sel];
    assign err = er[sel];

    // Observer: the PAL chain model plus burst/handshake/done accounting
    always @(negedge clk) begin
        if (cfg_en === 1'b1) begin
            en_cnt++;
            run++;
            bits.push_back(cfg_bit);
            chain = {chain[254:0], cfg_bit};
        end else if (run != 0) begin
            bursts++;
            if (run != 8) bad_burst++;
            run = 0;
        end
        if (ready === 1'b1) ready_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // CRC-8 as polynomial long division of message*x^8 by x^8+x^2+x+1
    function automatic logic [7:0] crc_ref();
        logic [8:0] rem = 9'h000;
        for (int i = 0; i < stream.size() * 8 + 8; i++) begin
            rem = {rem[7:0], (i < stream.size() * 8) ? stream[i / 8][7 - i % 8] : 1'b0};
            if (rem[8]) rem = rem ^ 9'h107;
        end
        return rem[7:0];
    endfunction

    function automatic int bit_errors();
        int bad = 0;
        if (bits.size() != stream.size() * 8) return -1;
        for (int i = 0; i < bits.size(); i++) if (bits[i] !== stream[i / 8][7 - i % 8]) bad++;
        return bad;
    endfunction

    task automatic clear_mon();
        en_cnt = 0; ready_cnt = 0; done_cnt = 0; bursts = 0; bad_burst = 0; run = 0;
        bits.delete();
        chain = '0;
    endtask

    task automatic random_stream(input int n);
        stream.delete();
        for (int i = 0; i < n; i++) stream.push_back(8'($urandom));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready !== 1'b1 && n < 300);
        ok = ready === 1'b1;
        if (!ok) begin
            checks++;
            $display("FAIL ready_timeout: ready=%b after %0d cycles, need 1", ready, n);
        end
    endtask

    task automatic do_load(input int stall_at, input bit start_mid);
        bit ok;
        int n = 0;
        clear_mon();
        pulse_start();
        for (int i = 0; i < stream.size(); i++) begin
            if (i == stall_at) begin
                valid = 1'b0;
                wait_ready(ok);
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    checks++;
                    if (ready !== 1'b1 || cfg_en !== 1'b0)
                        $display("FAIL stall_%0d: ready=%b cfg_en=%b, need ready=1 cfg_en=0", k, ready, cfg_en);
                    else passes++;
                end
                @(posedge clk); #1;
            end
            data_in = stream[i];
            valid = 1'b1;
            wait_ready(ok);
            @(posedge clk); #1;
            if (start_mid && i == 2) pulse_start();
        end
`ifdef PAL_CFG_CRC_EN
        data_in = bad_crc ? 8'h00 : crc_ref();
        wait_ready(ok);
        @(posedge clk); #1;
`endif
        valid = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 300);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) $display("FAIL done_pulse: done=%b busy=%b, need 1 1", done, busy);
        else passes++;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL done_fall: done=%b busy=%b, need 0 0", done, busy);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({rdy, en, cb, bsy, dn, er} !== 12'h000)
            $display("FAIL reset_outputs: got %h, need 000", {rdy, en, cb, bsy, dn, er});
        else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_a5();
        sel = 1'b0;
        stream.delete();
        repeat (24) stream.push_back(8'hA5);
        do_load(-1, 1'b0);
        checks++;
        if (en_cnt != 192) $display("FAIL a5_en_count: got %0d, need 192", en_cnt); else passes++;
        checks++;
        if (bursts != 24 || bad_burst != 0) $display("FAIL a5_bursts: got %0d bursts (%0d not 8 long), need 24 (0)", bursts, bad_burst);
        else passes++;
        checks++;
        if (ready_cnt != 24 + CRC_EXTRA) $display("FAIL a5_ready_cycles: got %0d, need %0d", ready_cnt, 24 + CRC_EXTRA);
        else passes++;
        checks++;
        if (bit_errors() != 0) $display("FAIL a5_bits: got %0d bit errors, need 0", bit_errors()); else passes++;
        checks++;
        if (done_cnt != 1) $display("FAIL a5_done_count: got %0d, need 1", done_cnt); else passes++;
    endtask

    task automatic test_short_chain();
        sel = 1'b1;
        stream.delete();
        stream.push_back(8'hF3);
        stream.push_back(8'h5C);
        do_load(-1, 1'b0);
        checks++;
        if (en_cnt != 16) $display("FAIL short_en_count: got %0d, need 16", en_cnt); else passes++;
        checks++;
        if (bit_errors() != 0) $display("FAIL short_bits: got %0d bit errors, need 0", bit_errors()); else passes++;
        checks++;
        if (chain[11:0] !== 12'h35C) $display("FAIL short_chain: got %h, need 35c", chain[11:0]); else passes++;
    endtask

    task automatic test_stall();
        sel = 1'b0;
        random_stream(24);
        do_load(4, 1'b0);
        checks++;
        if (en_cnt != 192 || bursts != 24 || bad_burst != 0)
            $display("FAIL stall_shifts: got %0d en cycles in %0d bursts (%0d bad), need 192 in 24 (0)", en_cnt, bursts, bad_burst);
        else passes++;
        checks++;
        if (bit_errors() != 0) $display("FAIL stall_bits: got %0d bit errors, need 0", bit_errors()); else passes++;
    endtask

    task automatic test_abort();
        bit ok;
        sel = 1'b0;
        random_stream(24);
        clear_mon();
        pulse_start();
        for (int i = 0; i <= 10; i++) begin
            data_in = stream[i];
            valid = 1'b1;
            wait_ready(ok);
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        checks++;
        if (cfg_en !== 1'b1 || ready !== 1'b0) $display("FAIL abort_cycle: cfg_en=%b ready=%b, need 1 0", cfg_en, ready);
        else passes++;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if (cfg_en !== 1'b0 || busy !== 1'b0 || ready !== 1'b0)
            $display("FAIL abort_after: cfg_en=%b busy=%b ready=%b, need 0 0 0", cfg_en, busy, ready);
        else passes++;
        repeat (5) @(negedge clk);
        checks++;
        if (en_cnt != 84 || done_cnt != 0 || ready_cnt != 11)
            $display("FAIL abort_totals: en=%0d done=%0d ready=%0d, need 84 0 11", en_cnt, done_cnt, ready_cnt);
        else passes++;
        @(posedge clk); #1;
        valid = 1'b0;
        random_stream(24);
        do_load(-1, 1'b0);
        checks++;
        if (en_cnt != 192 || bit_errors() != 0 || done_cnt != 1)
            $display("FAIL abort_restart: en=%0d bit_errors=%0d done=%0d, need 192 0 1", en_cnt, bit_errors(), done_cnt);
        else passes++;
        pulse_start();
        valid = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 1'b0) $display("FAIL abort_load_ready: got %b, need 0", ready); else passes++;
        @(posedge clk); #1;
        abort = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cfg_en !== 1'b0) $display("FAIL abort_load_idle: busy=%b cfg_en=%b, need 0 0", busy, cfg_en);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_start_busy();
        sel = 1'b0;
        random_stream(24);
        do_load(-1, 1'b1);
        checks++;
        if (en_cnt != 192 || done_cnt != 1 || bit_errors() != 0)
            $display("FAIL start_busy: en=%0d done=%0d bit_errors=%0d, need 192 1 0", en_cnt, done_cnt, bit_errors());
        else passes++;
    endtask

    task automatic test_crc();
        sel = 1'b1;
        stream.delete();
        stream.push_back(8'h01);
        stream.push_back(8'h02);
`ifdef PAL_CFG_CRC_EN
        bad_crc = 1'b0;
        do_load(-1, 1'b0);
        checks++;
        if (err !== 1'b0 || done_cnt != 1) $display("FAIL crc_good: err=%b done=%0d, need 0 1", err, done_cnt); else passes++;
        bad_crc = 1'b1;
        do_load(-1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1 || done_cnt != 1) $display("FAIL crc_bad: err=%b done=%0d, need 1 1", err, done_cnt); else passes++;
        @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        checks++;
        if (err !== 1'b0) $display("FAIL crc_clear: err=%b, need 0", err); else passes++;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        bad_crc = 1'b0;
`else
        do_load(-1, 1'b0);
        checks++;
        if (err !== 1'b0 || done_cnt != 1) $display("FAIL err_tied: err=%b done=%0d, need 0 1", err, done_cnt); else passes++;
`endif
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        sel = 1'b0;
        random_stream(24);
        clear_mon();
        pulse_start();
        data_in = stream[0];
        valid = 1'b1;
        wait_ready(ok);
        @(posedge clk); #1;
        valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (cfg_en !== 1'b0 || busy !== 1'b0 || ready !== 1'b0)
            $display("FAIL reset_mid: cfg_en=%b busy=%b ready=%b, need 0 0 0", cfg_en, busy, ready);
        else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
        do_load(-1, 1'b0);
        checks++;
        if (en_cnt != 192 || bit_errors() != 0) $display("FAIL reset_reload: en=%0d bit_errors=%0d, need 192 0", en_cnt, bit_errors());
        else passes++;
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_full_a5();
        test_short_chain();
        test_stall();
        test_abort();
        test_start_busy();
        test_crc();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/pal_cfg_loader.md
Name: pal_cfg_loader

Overview:
- Upstream feeder for the PAL configuration shift register.
- Accepts configuration bytes over a valid/ready handshake and serialises them into the PAL's serial config input and shift enable.
- Also counts the bitstream length and reports completion.
- Sits between the host-side byte interface (SPI/UART bridge) and the PAL CFG/EN pins.

Parameters:
- SR_LEN, 192, length of the PAL config chain in bits (2*N*P + P*M for N=M=P=8).
- W, 8, byte width of DATA_IN.
- NBYTES, ceil(SR_LEN/W) (derived localparam), bytes per full configuration.

Ports:
- CLK  in  1  system clock, rising edge.
- RES  in  1  reset, asynchronous, active-high.
- START  in  1  single-cycle request to begin a configuration load.
- ABORT  in  1  synchronous abort of a load in progress.
- DATA_IN  in  W  configuration byte.
- VALID  in  1  DATA_IN valid.
- READY  out  1  loader can accept DATA_IN this cycle.
- CFG_EN  out  1  drives PAL EN; the PAL chain shifts on every CLK edge where this is 1.
- CFG_BIT  out  1  drives PAL CFG; serial data.
- BUSY  out  1  load in progress (any state except IDLE).
- DONE  out  1  one-cycle pulse when the full stream has been shifted.
- ERR  out  1  checksum mismatch flag (see Optional Feature).

Behaviour:
- Reset (RES=1, asynchronous) values:
  - state=IDLE.
  - READY, CFG_EN, CFG_BIT, BUSY, DONE and ERR all 0.
  - Byte counter and bit counter 0.
- States: IDLE, LOAD, SHIFT, CHECK (feature only), FINISH.
- IDLE:
  - START=1 moves to LOAD next cycle.
  - ERR clears on START.
  - START in any other state is ignored.
- LOAD:
  - READY=1.
  - A handshake (VALID & READY) captures DATA_IN into the shift register and moves to SHIFT.
  - No handshake means stay in LOAD (wait indefinitely).
- SHIFT:
  - CFG_EN=1 for exactly W consecutive cycles.
  - CFG_BIT = shift register MSB; the register shifts left each cycle.
  - A byte accepted at edge t gives CFG_EN=1 in cycles t+1..t+W.
  - After the W-th bit, the byte counter increments.
  - If byte counter < NBYTES: go to LOAD. Otherwise go to CHECK (feature) or FINISH.
  - READY=0 throughout SHIFT, so gaps between bytes are permitted. CFG_EN=0 during gaps, so the PAL holds.
- Bit order:
  - Byte 0 is sent first, MSB-first within each byte.
  - After a full load, PAL chain bit SR_LEN-1 holds the first non-pad bit and chain bit 0 holds the last bit sent.
  - Padding: if SR_LEN % W != 0, the leading (NBYTES*W - SR_LEN) MSBs of byte 0 are pad. They are still shifted and fall off the chain end. Total shift cycles are always NBYTES*W.
- FINISH:
  - DONE=1 for one cycle.
  - Return to IDLE; BUSY drops in the same cycle DONE falls.
- ABORT:
  - In LOAD, SHIFT or CHECK, ABORT=1 moves to IDLE next cycle.
  - CFG_EN deasserts that same next cycle; the PAL keeps the partial config.
  - Counters clear. DONE is not pulsed.
  - ABORT in IDLE has no effect.
  - ABORT has priority over a simultaneous handshake; the byte is not consumed, so READY is forced 0 when ABORT=1.
- Reset mid-load: all state is lost immediately, CFG_EN=0, and the PAL contents are undefined until the next full load.
- Counters:
  - Bit counter width is clog2(W+1); byte counter width is clog2(NBYTES+1).
  - Neither counter wraps, because both are cleared on state exit.

Optional Feature:
- Macro: PAL_CFG_CRC_EN.
- Defined:
  - A running CRC-8 (poly 0x07, init 0x00, MSB-first) is updated over every accepted config byte.
  - After the last config byte has been shifted, the FSM enters CHECK with READY=1, accepts one more byte (the CRC) and does not shift it.
  - ERR is set to (received != computed) and held until the next START or reset.
  - The FSM then goes to FINISH; DONE pulses regardless of ERR.
- Undefined: no CRC logic, no CHECK state, and ERR is tied to 0.

Test Plan:
- Default params, 24 bytes 0xA5 streamed with VALID always 1 -> READY high for 1 cycle per byte, 192 CFG_EN cycles in 24 bursts of 8, CFG_BIT pattern 1,0,1,0,0,1,0,1 repeated, DONE pulses once, BUSY falls with it.
- SR_LEN=12, W=8, bytes 0xF3,0x5C -> 16 CFG_EN cycles, CFG_BIT = 1111 0011 0101 1100; captured chain model equals 0x35C.
- Stall VALID low for 5 cycles between byte 3 and byte 4 -> CFG_EN=0 and READY=1 during the stall, no extra shifts; total CFG_EN count still 192.
- ABORT asserted on the 4th SHIFT cycle of byte 10 with VALID=1 -> CFG_EN=0 next cycle, state IDLE, no DONE, READY stays 0; START restarts at byte 0.
- START while BUSY -> ignored, byte counter unchanged.
- With PAL_CFG_CRC_EN, SR_LEN=16, bytes 0x01,0x02, CRC byte 0x1B -> ERR=0, DONE pulses. Repeat with CRC byte 0x00 -> ERR=1, DONE pulses. ERR clears on the next START.
